mc_sequencer: RTL
=================

# mc_sequencer

Multicycle main sequencer for the ARM processor. It replaces the single-cycle instruction decode path with a Moore state machine that steps the shared datapath through fetch, decode, execute, memory and writeback. It also holds in fetch and memory states until the unified instruction/data memory signals ready. Its raw write strobes feed the existing condition logic, which gates them with the condition check; the ALU decoder and immediate/register-source decode stay outside this block.

## Interface
- No parameters; the 4-bit state encoding is fixed below.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S, Funct[4]=L for branches
- mem_ready  in  1  memory completed the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  load PC with PC+4
- AdrSrc  out  1  0=PC, 1=ALU result as memory address
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
- ALUOp  out  1  1=ALU decoder uses Funct, 0=add
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result
- RegW, MemW, Branch  out  1 each  raw strobes to condition logic
- Link  out  1  select R14 as write destination
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  4  current state, for debug

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE if mem_ready, else stay in FETCH.
  - DECODE -> MEMADR if Op=01; -> EXECI if Op=00 and Funct[5]; -> EXECR if Op=00 and !Funct[5]; -> BRANCH if Op=10; -> FETCH if Op=11 (treated as a NOP).
  - MEMADR -> MEMRD if Funct[0] (LDR), else -> MEMWR.
  - MEMRD -> MEMWB if mem_ready, else stay in MEMRD.
  - MEMWR -> FETCH if mem_ready, else stay in MEMWR.
  - EXECR and EXECI -> FETCH if Funct[4:1] is 1010 or 1011 (CMP/CMN, no writeback); otherwise -> ALUWB.
  - MEMWB, ALUWB and BRANCH -> FETCH.
- Outputs are Moore-decoded from state. Every output not listed for a state is 0.
  - FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1, held while waiting.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1; Link=RegW=Funct[4].
- instr_done=1 in MEMWB, ALUWB and BRANCH, in MEMWR when mem_ready, in EXECR/EXECI when CMP/CMN, and in DECODE when Op=11.
- Op and Funct are sampled from the instruction register, which is stable from DECODE onward; Op and Funct values in FETCH are ignored.

## Timing
- Reset: while reset=0, state=FETCH and every output is forced to 0, including IRWrite and NextPC; state reads 0. After reset releases, outputs follow FETCH decode combinationally.
- Minimum cycles with mem_ready held at 1:
  - LDR 5
  - STR 4
  - data-processing with writeback 4
  - CMP/CMN 3
  - B/BL 3
  - Op=11 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. The outputs of a waiting state are stable across its wait cycles.
- Reset asserted mid-instruction returns to FETCH immediately, asynchronously, with no write strobe emitted. A MemW in progress is dropped in the same cycle.
- The block has no combinational path from mem_ready to state; mem_ready reaches outputs only through IRWrite/NextPC in FETCH and instr_done in MEMWR.

## Test plan
- Reset: hold reset=0 for 3 cycles with mem_ready=1 -> all outputs 0, state=0. After release: IRWrite=1, NextPC=1, ALUSrcB=10.
- ADD register (Op=00, Funct=001000), mem_ready=1 -> state sequence 0,1,6,8,0. RegW=1 only in ALUWB; instr_done pulses once; ALUOp=1 in EXECR.
- CMP immediate (Funct=110101) -> sequence 0,1,7,0. RegW stays 0 throughout; instr_done=1 in EXECI.
- LDR (Op=01, Funct=011001), mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. AdrSrc=1 for all 3 MEMRD cycles; ResultSrc=01 with RegW=1 in MEMWB.
- STR, then reset pulled low during the second MEMWR wait cycle -> MemW drops to 0 asynchronously and state=0. After release, the next fetch behaves normally.
- BL (Op=10, Funct=010000) -> sequence 0,1,9,0 with Branch=1, Link=1, RegW=1 in BRANCH. B (Funct=000000) gives Link=0 and RegW=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multicycle main sequencer: Moore FSM stepping the shared datapath through
// fetch, decode, execute, memory and writeback, stalling on mem_ready.
module mc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Link,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   no_wb;

  // CMP (1010) and CMN (1011) only set flags.
  assign no_wb = (Funct[4:2] == 3'b101);
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExecR,
      StExecI:  state_d = no_wb ? StFetch : StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 1'b0;
    ResultSrc  = 2'b00;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    Link       = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
      end
      StDecode: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        instr_done = (Op == 2'b11);
      end
      StMemAdr: ALUSrcB = 2'b01;
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        AdrSrc     = 1'b1;
        MemW       = 1'b1;
        instr_done = mem_ready;
      end
      StExecR: begin
        ALUOp      = 1'b1;
        instr_done = no_wb;
      end
      StExecI: begin
        ALUSrcB    = 2'b01;
        ALUOp      = 1'b1;
        instr_done = no_wb;
      end
      StAluWb: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        Branch     = 1'b1;
        Link       = Funct[4];
        RegW       = Funct[4];
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset forces every strobe low, including the mem_ready-driven ones.
    if (!reset) begin
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 1'b0;
      ResultSrc  = 2'b00;
      RegW       = 1'b0;
      MemW       = 1'b0;
      Branch     = 1'b0;
      Link       = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
